// File: rtl/dest_drain_pkg.sv
// Shared types and constants for the destination drain arbiter.
package dest_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } drain_state_e;

  localparam int unsigned DRAIN_DATA_WIDTH = 6;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

endpackage

// File: rtl/dest_drain_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the caller registers last_grant.
module rr_arb2
  import dest_drain_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       grant_valid_o
);

  always_comb begin
    grant_valid_o = |req_i;
    case (req_i)
      2'b11:   grant_o = ~last_grant_i;
      2'b10:   grant_o = SRC_D1;
      default: grant_o = SRC_D0;
    endcase
  end

endmodule

// File: rtl/dest_drain_arbiter.sv
// Drains destination FIFOs D0/D1 round-robin into one valid/ready stream.
// Define DRAIN_CNT_EN to build the saturating per-source word counters.
module dest_drain_arbiter
  import dest_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DRAIN_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active_in,
  input  logic                  empty_fifo_D0,
  input  logic                  empty_fifo_D1,
  input  logic [DATA_WIDTH-1:0] data_out_D0,
  input  logic [DATA_WIDTH-1:0] data_out_D1,
  output logic                  D0_pop,
  output logic                  D1_pop,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_src,
  output logic [CNT_WIDTH-1:0]  cnt_D0,
  output logic [CNT_WIDTH-1:0]  cnt_D1
);

  drain_state_e          state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic                  pop0_q, pop0_d;
  logic                  pop1_q, pop1_d;
  logic                  valid_q, valid_d;
  logic                  src_q, src_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [1:0] req;
  logic       arb_grant;
  logic       arb_valid;
  logic       issue;
  logic       handshake;

  assign req       = {active_in & ~empty_fifo_D1, active_in & ~empty_fifo_D0};
  assign handshake = valid_q & out_ready;

  rr_arb2 u_arb (
    .req_i         (req),
    .last_grant_i  (last_q),
    .grant_o       (arb_grant),
    .grant_valid_o (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    pop0_d  = 1'b0;
    pop1_d  = 1'b0;
    valid_d = valid_q;
    src_d   = src_q;
    data_d  = data_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: issue = arb_valid;
      // READ spans the pop cycle plus the FIFO read-data cycle; the pop flop marks the first.
      READ: begin
        if (!(pop0_q || pop1_q)) begin
          data_d  = (grant_q == SRC_D1) ? data_out_D1 : data_out_D0;
          src_d   = grant_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          valid_d = 1'b0;
          state_d = IDLE;
          issue   = arb_valid;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      grant_d = arb_grant;
      last_d  = arb_grant;
      pop0_d  = (arb_grant == SRC_D0);
      pop1_d  = (arb_grant == SRC_D1);
      state_d = READ;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= SRC_D0;
      last_q  <= SRC_D1;
      pop0_q  <= 1'b0;
      pop1_q  <= 1'b0;
      valid_q <= 1'b0;
      src_q   <= SRC_D0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      pop0_q  <= pop0_d;
      pop1_q  <= pop1_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      data_q  <= data_d;
    end
  end

  assign D0_pop    = pop0_q;
  assign D1_pop    = pop1_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;

`ifdef DRAIN_CNT_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (handshake && (src_q == SRC_D0) && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
      if (handshake && (src_q == SRC_D1) && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign cnt_D0 = cnt0_q;
  assign cnt_D1 = cnt1_q;
`else
  assign cnt_D0 = '0;
  assign cnt_D1 = '0;
`endif

endmodule

// File: tb/tb_dest_drain_arbiter.sv
// Self-checking bench for dest_drain_arbiter: directed vector table, hand sequences, random vs. model.
module tb_dest_drain_arbiter;

  localparam int unsigned DW = 6;
  localparam int unsigned CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, active_in, empty_fifo_D0, empty_fifo_D1;
  logic          D0_pop, D1_pop, out_ready, out_valid, out_src;
  logic [DW-1:0] data_out_D0, data_out_D1, out_data;
  logic [CW-1:0] cnt_D0, cnt_D1;

  dest_drain_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .active_in     (active_in),
    .empty_fifo_D0 (empty_fifo_D0),
    .empty_fifo_D1 (empty_fifo_D1),
    .data_out_D0   (data_out_D0),
    .data_out_D1   (data_out_D1),
    .D0_pop        (D0_pop),
    .D1_pop        (D1_pop),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_src       (out_src),
    .cnt_D0        (cnt_D0),
    .cnt_D1        (cnt_D1)
  );

  // FIFO contents seen by the DUT
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: one word outstanding, round-robin by last winner.
  bit            m_busy, m_last, m_src;
  int            m_age, m_cnt0, m_cnt1;
  logic [DW-1:0] m_data;
  logic [1:0]    m_pop;
  bit            s_free, s_act, s_e0, s_e1;

  typedef struct {
    bit            rst;
    bit            p0v;
    logic [DW-1:0] p0d;
    bit            p1v;
    logic [DW-1:0] p1d;
    bit            act;
    bit            rdy;
    logic [1:0]    pop;
    bit            vld;
    logic [DW-1:0] dat;
    bit            src;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(bit rst, bit p0v, logic [DW-1:0] p0d, bit p1v, logic [DW-1:0] p1d,
                              bit act, bit rdy, logic [1:0] pop, bit vld, logic [DW-1:0] dat, bit src);
    vec_t v;
    v.rst = rst; v.p0v = p0v; v.p0d = p0d; v.p1v = p1v; v.p1d = p1d;
    v.act = act; v.rdy = rdy; v.pop = pop; v.vld = vld; v.dat = dat; v.src = src;
    tbl.push_back(v);
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_last = 1; m_src = 0; m_age = 0; m_data = '0;
    m_cnt0 = 0; m_cnt1 = 0; m_pop = 2'b00;
    s_free = 1; s_act = 0; s_e0 = 1; s_e1 = 1;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    active_in = 1'b0; out_ready = 1'b0;
    q0.delete(); q1.delete();
    empty_fifo_D0 = 1'b1; empty_fifo_D1 = 1'b1;
    data_out_D0 = '0; data_out_D1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  // One clock: model decision, FIFO response to DUT pops, new stimulus, then mid-cycle checks.
  task automatic step(input bit p0v, input logic [DW-1:0] p0d, input bit p1v, input logic [DW-1:0] p1d,
                      input bit act, input bit rdy);
    bit g;
    bit ev;
    @(posedge clk); #1;
    m_pop = 2'b00;
    if (s_free && s_act && !(s_e0 && s_e1)) begin
      g = (!s_e0 && !s_e1) ? ~m_last : s_e0;
      m_last = g;
      m_pop  = g ? 2'b10 : 2'b01;
      m_busy = 1; m_age = 0; m_src = g;
      m_data = g ? q1[0] : q0[0];
    end else if (m_busy && m_age < 2) begin
      m_age++;
    end
    if (D0_pop && q0.size() > 0) data_out_D0 = q0.pop_front();
    if (D1_pop && q1.size() > 0) data_out_D1 = q1.pop_front();
    if (p0v) q0.push_back(p0d);
    if (p1v) q1.push_back(p1d);
    empty_fifo_D0 = (q0.size() == 0);
    empty_fifo_D1 = (q1.size() == 0);
    active_in = act;
    out_ready = rdy;
    @(negedge clk);
    chk("pop", {D1_pop, D0_pop}, m_pop);
    ev = m_busy && (m_age == 2);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out_data", out_data, m_data);
      chk("out_src", out_src, m_src);
    end
    chk("cnt_D0", cnt_D0, m_cnt0);
    chk("cnt_D1", cnt_D1, m_cnt1);
    if (ev && out_ready) begin
      m_busy = 0;
`ifdef DRAIN_CNT_EN
      if (m_src) begin
        if (m_cnt1 < CNT_MAX) m_cnt1++;
      end else begin
        if (m_cnt0 < CNT_MAX) m_cnt0++;
      end
`endif
    end
    s_free = !m_busy;
    s_act  = active_in;
    s_e0   = empty_fifo_D0;
    s_e1   = empty_fifo_D1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    // single D0 word
    add(1, 1, 6'h2A, 0, 0, 1, 1, 2'b00, 0, 0, 0);
    add(0, 0, 0,     0, 0, 1, 1, 2'b01, 0, 0, 0);
    add(0, 0, 0,     0, 0, 1, 1, 2'b00, 0, 0, 0);
    add(0, 0, 0,     0, 0, 1, 1, 2'b00, 1, 6'h2A, 0);
    add(0, 0, 0,     0, 0, 1, 1, 2'b00, 0, 0, 0);
    // both preloaded: 01,11,02,12
    add(1, 1, 6'h01, 1, 6'h11, 1, 1, 2'b00, 0, 0, 0);
    add(0, 1, 6'h02, 1, 6'h12, 1, 1, 2'b01, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2'b00, 1, 6'h01, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2'b10, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2'b00, 1, 6'h11, 1);
    add(0, 0, 0, 0, 0, 1, 1, 2'b01, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2'b00, 1, 6'h02, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2'b10, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2'b00, 1, 6'h12, 1);
    add(0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0);
    // backpressure: 5 cycles held, no pops while D1 waits
    add(1, 1, 6'h33, 0, 0,     1, 0, 2'b00, 0, 0, 0);
    add(0, 0, 0,     0, 0,     1, 0, 2'b01, 0, 0, 0);
    add(0, 0, 0,     1, 6'h04, 1, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 1, 0, 2'b00, 1, 6'h33, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2'b00, 1, 6'h33, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2'b10, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 2'b00, 1, 6'h04, 1);
    add(0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0);
    // active dropped in the READ cycle
    add(1, 1, 6'h01, 1, 6'h11, 1, 1, 2'b00, 0, 0, 0);
    add(0, 1, 6'h02, 1, 6'h12, 0, 1, 2'b01, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 2'b00, 1, 6'h01, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0);

    reset = 1'b1;
    do_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_pops", {D1_pop, D0_pop}, 2'b00);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_src", out_src, 1'b0);
    chk("rst_cnt", {cnt_D1, cnt_D0}, '0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].p0v, tbl[i].p0d, tbl[i].p1v, tbl[i].p1d, tbl[i].act, tbl[i].rdy);
      chk($sformatf("tbl%0d_pop", i), {D1_pop, D0_pop}, tbl[i].pop);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_data", i), out_data, tbl[i].dat);
        chk($sformatf("tbl%0d_src", i), out_src, tbl[i].src);
      end
    end

    // asynchronous reset while a word is held
    do_reset();
    step(1, 6'h15, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    chk("hold_before_reset", out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_pops", {D1_pop, D0_pop}, 2'b00);
    chk("async_rst_data", out_data, '0);
    do_reset();

    // 300 D1 words for counter saturation
    for (int i = 0; i < 300; i++) step(0, 0, 1, 6'(i), 1, 1);
    for (int i = 0; i < 1000 && (q1.size() > 0 || m_busy); i++) step(0, 0, 0, 0, 1, 1);
    chk("drain_done", (q1.size() == 0 && !m_busy), 1'b1);
    step(0, 0, 0, 0, 1, 1);
`ifdef DRAIN_CNT_EN
    chk("cnt_D1_saturated", cnt_D1, CNT_MAX);
`else
    chk("cnt_D1_tied", cnt_D1, 0);
`endif
    chk("cnt_D0_untouched", cnt_D0, 0);

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit p0v, p1v, act, rdy;
      p0v = ($urandom_range(0, 2) == 0) && (q0.size() < 6);
      p1v = ($urandom_range(0, 2) == 0) && (q1.size() < 6);
      act = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      step(p0v, 6'($urandom), p1v, 6'($urandom), act, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
